// File: rtl/histogram_pkg.sv
// histogram_pkg
// Shared types and helpers for the grey-level histogram engine and its RAM.
//   histState_t : engine FSM states (CLEAR, IDLE, DRAIN, READ)
//   nbins()     : number of bins for a given grey-level width
//   max_count() : saturation value of a bin counter of a given width
package histogram_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DRAIN = 2'd2,
        READ  = 2'd3
    } histState_t;

    // One bin per grey level.
    function automatic int nbins(input int addrWidth);
        return 1 << addrWidth;
    endfunction

    // All-ones value of a counter; a bin holding this value no longer increments.
    function automatic logic [63:0] max_count(input int dataWidth);
        return (64'd1 << dataWidth) - 64'd1;
    endfunction

endpackage

// File: rtl/histogram_ram.sv
// histogram_ram
// Simple dual-port RAM, one write port and one registered read port.
// A read of the address being written in the same cycle returns the old
// contents, so callers that need the new value must forward it themselves.
// Ports:
//   iClk    : clock, rising edge
//   iWe     : write enable
//   iWAddr  : write address
//   iWData  : write data
//   iRAddr  : read address, sampled every cycle
//   oRData  : read data, valid the cycle after iRAddr
module histogram_ram
    import histogram_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  iClk,
    input  logic                  iWe,
    input  logic [ADDR_WIDTH-1:0] iWAddr,
    input  logic [DATA_WIDTH-1:0] iWData,
    input  logic [ADDR_WIDTH-1:0] iRAddr,
    output logic [DATA_WIDTH-1:0] oRData
);

    localparam int DEPTH = nbins(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset on the array or the read register so the tools can map this
    // onto a block RAM; the engine clears the contents with its own sweep.
    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[iWAddr] <= iWData;
        end
        oRData <= mem[iRAddr];
    end

endmodule

// File: rtl/histogram_engine.sv
// histogram_engine
// Accumulates a per-grey-level histogram from a pixel stream and streams it
// back out together with its running cumulative sum.
// Ports:
//   iClk       : clock, rising edge
//   iRst_n     : asynchronous active-low reset
//   iClear     : pulse, start a clear sweep (from IDLE, DRAIN or READ)
//   iInc       : pixel valid, count bin iGray (accepted in IDLE only)
//   iGray      : pixel grey level
//   iReadStart : pulse, start a readout sweep (from IDLE only)
//   oBusy      : high while clearing, draining or reading out
//   oValid     : readout beat valid
//   oBin       : bin of the current beat
//   oCount     : count of oBin
//   oCdf       : sum of counts of bins 0..oBin
//   oDone      : pulse the cycle after the last beat
//   oSat       : sticky, some increment hit a saturated bin since the last clear
module histogram_engine
    import histogram_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 8,
    parameter int CDF_WIDTH  = DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iClear,
    input  logic                  iInc,
    input  logic [ADDR_WIDTH-1:0] iGray,
    input  logic                  iReadStart,
    output logic                  oBusy,
    output logic                  oValid,
    output logic [ADDR_WIDTH-1:0] oBin,
    output logic [DATA_WIDTH-1:0] oCount,
    output logic [CDF_WIDTH-1:0]  oCdf,
    output logic                  oDone,
    output logic                  oSat
);

    localparam int                    NBINS     = nbins(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN  = ADDR_WIDTH'(NBINS - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_COUNT = DATA_WIDTH'(max_count(DATA_WIDTH));

    histState_t state, nextState;

    logic [ADDR_WIDTH-1:0] clrAddr;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic                  readIssuing;
    logic                  p1Valid;
    logic [ADDR_WIDTH-1:0] p1Bin;

    logic                  rValid;
    logic [ADDR_WIDTH-1:0] rAddr;
    logic                  wValid;
    logic [ADDR_WIDTH-1:0] wAddr;
    logic                  fwdHit;
    logic [DATA_WIDTH-1:0] fwdData;

    logic                  accept;
    logic [DATA_WIDTH-1:0] oldCount;
    logic [DATA_WIDTH-1:0] newCount;
    logic                  atMax;

    logic                  ramWe;
    logic [ADDR_WIDTH-1:0] ramWAddr;
    logic [DATA_WIDTH-1:0] ramWData;
    logic [ADDR_WIDTH-1:0] ramRAddr;
    logic [DATA_WIDTH-1:0] ramRData;

    // Reset lands in CLEAR because the RAM powers up with arbitrary contents.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= CLEAR;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. iClear takes priority everywhere except inside the
    // clear sweep itself; DRAIN holds off the readout until the last
    // in-flight increment has been written.
    always_comb begin
        nextState = state;
        case (state)
            CLEAR: if (clrAddr == LAST_BIN) nextState = IDLE;
            IDLE: begin
                if (iClear) nextState = CLEAR;
                else if (iReadStart) nextState = DRAIN;
            end
            DRAIN: begin
                if (iClear) nextState = CLEAR;
                else if (!rValid && !wValid) nextState = READ;
            end
            READ: begin
                if (iClear) nextState = CLEAR;
                else if (oDone) nextState = IDLE;
            end
            default: nextState = CLEAR;
        endcase
    end

    // Busy is gated by the reset input so that it reads 0 while reset is held
    // and rises as soon as the power-on sweep actually starts.
    assign oBusy = iRst_n && (state != IDLE);

    // Increment datapath. fwdHit marks that the RAM read for the bin now in
    // stage W coincided with the write of that same bin, so the RAM returned
    // the stale value and the captured write value is used instead. The write
    // port belongs to the sweep in CLEAR and to stage W otherwise.
    always_comb begin
        accept   = (state == IDLE) && iInc && !iClear;
        oldCount = fwdHit ? fwdData : ramRData;
        atMax    = (oldCount == MAX_COUNT);
        newCount = atMax ? oldCount : oldCount + DATA_WIDTH'(1);
        ramWe    = (state == CLEAR) || wValid;
        ramWAddr = (state == CLEAR) ? clrAddr : wAddr;
        ramWData = (state == CLEAR) ? '0 : newCount;
        ramRAddr = (state == READ) ? readAddr : rAddr;
    end

    // Two-stage read-modify-write pipeline. Entering CLEAR flushes it, which
    // squashes any increment still in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rValid  <= 1'b0;
            rAddr   <= '0;
            wValid  <= 1'b0;
            wAddr   <= '0;
            fwdHit  <= 1'b0;
            fwdData <= '0;
        end else begin
            if (accept) begin
                rAddr <= iGray;
            end
            wAddr   <= rAddr;
            fwdData <= newCount;
            if (state == CLEAR) begin
                rValid <= 1'b0;
                wValid <= 1'b0;
                fwdHit <= 1'b0;
            end else begin
                rValid <= accept;
                wValid <= rValid;
                fwdHit <= rValid && wValid && (rAddr == wAddr);
            end
        end
    end

    // Sweep counters and readout pipeline. The read address is issued in
    // READ, the registered RAM data lands one cycle later (p1), and the
    // output registers with the running sum follow one cycle after that.
    // Aborting with iClear drops the valids at once so no beat or done leaks.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            clrAddr     <= '0;
            readAddr    <= '0;
            readIssuing <= 1'b0;
            p1Valid     <= 1'b0;
            p1Bin       <= '0;
            oValid      <= 1'b0;
            oBin        <= '0;
            oCount      <= '0;
            oCdf        <= '0;
            oDone       <= 1'b0;
            oSat        <= 1'b0;
        end else begin
            clrAddr <= (state == CLEAR) ? clrAddr + ADDR_WIDTH'(1) : '0;

            if (state == DRAIN) begin
                readAddr    <= '0;
                readIssuing <= 1'b1;
            end else if (state == READ && readIssuing) begin
                readAddr <= readAddr + ADDR_WIDTH'(1);
                if (readAddr == LAST_BIN) begin
                    readIssuing <= 1'b0;
                end
            end

            p1Valid <= (state == READ) && !iClear && readIssuing;
            p1Bin   <= readAddr;
            oValid  <= (state == READ) && !iClear && p1Valid;
            oDone   <= (state == READ) && !iClear && oValid && (oBin == LAST_BIN);

            if (p1Valid) begin
                oBin   <= p1Bin;
                oCount <= ramRData;
                oCdf   <= (p1Bin == '0) ? CDF_WIDTH'(ramRData)
                                        : oCdf + CDF_WIDTH'(ramRData);
            end

            if (state == CLEAR) begin
                oSat <= 1'b0;
            end else if (wValid && atMax) begin
                oSat <= 1'b1;
            end
        end
    end

    histogram_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) binRam (
        .iClk  (iClk),
        .iWe   (ramWe),
        .iWAddr(ramWAddr),
        .iWData(ramWData),
        .iRAddr(ramRAddr),
        .oRData(ramRData)
    );

endmodule

// File: tb/tb_histogram_engine.sv
// tb_histogram_engine
// Directed bench for histogram_engine. A default-width instance carries the
// accumulate, readout, clear and abort scenarios; a second instance with
// 4-bit counters covers saturation.
module tb_histogram_engine;

    logic        clock = 1'b0;
    logic        rstN;

    logic        iClear, iInc, iReadStart;
    logic [7:0]  iGray;
    logic        oBusy, oValid, oDone, oSat;
    logic [7:0]  oBin;
    logic [19:0] oCount;
    logic [27:0] oCdf;

    logic        sClear, sInc, sReadStart;
    logic [7:0]  sGray;
    logic        sBusy, sValid, sDone, sSat;
    logic [7:0]  sBin;
    logic [3:0]  sCount;
    logic [11:0] sCdf;

    int          vecCount  = 0;
    int          missCount = 0;
    int          expCount [256];
    logic [63:0] capCount [256];
    logic [63:0] capCdf [256];
    int          capBin [256];

    histogram_engine dut (
        .iClk      (clock),
        .iRst_n    (rstN),
        .iClear    (iClear),
        .iInc      (iInc),
        .iGray     (iGray),
        .iReadStart(iReadStart),
        .oBusy     (oBusy),
        .oValid    (oValid),
        .oBin      (oBin),
        .oCount    (oCount),
        .oCdf      (oCdf),
        .oDone     (oDone),
        .oSat      (oSat)
    );

    histogram_engine #(.DATA_WIDTH(4)) dutSat (
        .iClk      (clock),
        .iRst_n    (rstN),
        .iClear    (sClear),
        .iInc      (sInc),
        .iGray     (sGray),
        .iReadStart(sReadStart),
        .oBusy     (sBusy),
        .oValid    (sValid),
        .oBin      (sBin),
        .oCount    (sCount),
        .oCdf      (sCdf),
        .oDone     (sDone),
        .oSat      (sSat)
    );

    // Free-running 10 ns clock; stimulus and sampling both happen on the
    // falling edge, half a period away from the active edge.
    always #5 clock = ~clock;

    // Safety net in case some bounded loop is itself broken.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] want);
        vecCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Drives the main instance inputs for exactly one clock, then idles them.
    task automatic applyStimulus(input logic inc, input logic [7:0] gray,
                                 input logic clr, input logic rs);
        iInc       = inc;
        iGray      = gray;
        iClear     = clr;
        iReadStart = rs;
        @(negedge clock);
        iInc       = 1'b0;
        iClear     = 1'b0;
        iReadStart = 1'b0;
    endtask

    // Counts samples while busy (optionally hammering iInc on bin 5), and
    // counts any done pulses seen on the way.
    task automatic waitIdle(input bit incDuring, output int n, output int dones);
        n     = 0;
        dones = 0;
        iInc  = incDuring;
        iGray = 8'd5;
        while (oBusy && n < 2000) begin
            if (oDone) dones++;
            n++;
            @(negedge clock);
        end
        iInc = 1'b0;
    endtask

    // Pulses iClear and expects the sweep to last exactly one cycle per bin.
    task automatic doClear(input string tag, input bit incDuring);
        int n, d;
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        waitIdle(incDuring, n, d);
        checkOutput({tag, " sweep cycles"}, n, 256);
    endtask

    // Runs one full readout, capturing every beat, then compares each bin
    // and its running sum against expCount.
    task automatic runReadout(input string tag, input bit withInc, input bit incDuring);
        int  beats, dones, gaps, cyc;
        bit  seenValid, finished;
        logic [63:0] running;
        beats = 0; dones = 0; gaps = 0; cyc = 0;
        seenValid = 0; finished = 0;
        iReadStart = 1'b1;
        iInc       = withInc;
        iGray      = 8'd42;
        @(negedge clock);
        iReadStart = 1'b0;
        iInc       = incDuring;
        iGray      = 8'd5;
        while (!finished && cyc < 700) begin
            if (oValid) begin
                if (beats < 256) begin
                    capCount[beats] = 64'(oCount);
                    capCdf[beats]   = 64'(oCdf);
                    capBin[beats]   = int'(oBin);
                end
                beats++;
                seenValid = 1;
            end else if (seenValid && beats < 256) begin
                gaps++;
            end
            if (oDone) dones++;
            if (dones > 0 && !oBusy) begin
                finished = 1;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        iInc = 1'b0;
        checkOutput({tag, " finished"}, 64'(finished), 1);
        checkOutput({tag, " beats"}, beats, 256);
        checkOutput({tag, " done pulses"}, dones, 1);
        checkOutput({tag, " valid gaps"}, gaps, 0);
        running = 0;
        for (int b = 0; b < 256; b++) begin
            running = running + 64'(expCount[b]);
            checkOutput($sformatf("%s bin idx %0d", tag, b), 64'(capBin[b]), 64'(b));
            checkOutput($sformatf("%s count %0d", tag, b), capCount[b], 64'(expCount[b]));
            checkOutput($sformatf("%s cdf %0d", tag, b), capCdf[b], running);
        end
    endtask

    // Main scenario sequence.
    initial begin
        int n, d;
        bit reached;
        rstN = 1'b0;
        iClear = 0; iInc = 0; iReadStart = 0; iGray = '0;
        sClear = 0; sInc = 0; sReadStart = 0; sGray = '0;
        repeat (3) @(negedge clock);

        checkOutput("reset busy", 64'(oBusy), 0);
        checkOutput("reset valid", 64'(oValid), 0);
        checkOutput("reset done", 64'(oDone), 0);
        checkOutput("reset sat", 64'(oSat), 0);
        checkOutput("reset cdf", 64'(oCdf), 0);

        rstN = 1'b1;
        #1;
        waitIdle(1'b0, n, d);
        checkOutput("power-on sweep cycles", n, 256);
        checkOutput("sat inst idle after sweep", 64'(sBusy), 0);

        for (int b = 0; b < 256; b++) expCount[b] = 0;
        runReadout("empty", 1'b0, 1'b0);

        // Back-to-back hits on bin 7, then every-other-cycle 7/9.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd9, 1'b0, 1'b0);
        expCount[7] = 7;
        expCount[9] = 2;
        runReadout("bins7_9", 1'b0, 1'b0);
        checkOutput("bins7_9 last cdf", capCdf[255], 9);
        checkOutput("main sat stays low", 64'(oSat), 0);

        // Saturation on the 4-bit instance: 15 hits fill bin 3 without
        // flagging; the next attempts set the sticky flag.
        for (int i = 0; i < 15; i++) begin
            sInc = 1'b1; sGray = 8'd3;
            @(negedge clock);
        end
        sInc = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("sat after 15 incs", 64'(sSat), 0);
        for (int i = 0; i < 5; i++) begin
            sInc = 1'b1; sGray = 8'd3;
            @(negedge clock);
        end
        sInc = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("sat after 20 incs", 64'(sSat), 1);
        sReadStart = 1'b1;
        @(negedge clock);
        sReadStart = 1'b0;
        reached = 0;
        for (int c = 0; c < 600 && !reached; c++) begin
            if (sValid && sBin == 8'd3) reached = 1;
            else @(negedge clock);
        end
        checkOutput("sat readout reached bin 3", 64'(reached), 1);
        checkOutput("sat bin 3 count", 64'(sCount), 15);
        n = 0;
        while (sBusy && n < 2000) begin n++; @(negedge clock); end
        checkOutput("sat readout ended", 64'(sBusy), 0);
        sClear = 1'b1;
        @(negedge clock);
        sClear = 1'b0;
        n = 0;
        while (sBusy && n < 2000) begin n++; @(negedge clock); end
        checkOutput("sat clear sweep cycles", n, 256);
        checkOutput("sat after clear", 64'(sSat), 0);

        // Increments still in the pipeline when iClear arrives are squashed.
        applyStimulus(1'b1, 8'd200, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd200, 1'b0, 1'b0);
        doClear("squash", 1'b0);

        // One hit on every bin: cdf at bin k is k+1.
        for (int b = 0; b < 256; b++) applyStimulus(1'b1, 8'(b), 1'b0, 1'b0);
        for (int b = 0; b < 256; b++) expCount[b] = 1;
        runReadout("ramp", 1'b0, 1'b0);
        checkOutput("ramp last cdf", capCdf[255], 256);

        // Increments during CLEAR and READ are dropped; one coinciding with
        // iReadStart in IDLE is counted.
        doClear("inc during clear", 1'b1);
        for (int b = 0; b < 256; b++) expCount[b] = 0;
        expCount[42] = 1;
        runReadout("inc with start", 1'b1, 1'b1);
        runReadout("recheck", 1'b0, 1'b0);

        // Abort the readout at beat 100.
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        reached = 0;
        for (int c = 0; c < 600 && !reached; c++) begin
            if (oValid && oBin == 8'd100) reached = 1;
            else @(negedge clock);
        end
        checkOutput("abort reached beat 100", 64'(reached), 1);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        checkOutput("abort valid drops", 64'(oValid), 0);
        waitIdle(1'b0, n, d);
        checkOutput("abort sweep cycles", n, 256);
        checkOutput("abort no done", d, 0);
        for (int b = 0; b < 256; b++) expCount[b] = 0;
        runReadout("after abort", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/histogram_engine.md
Name: histogram_engine

Overview:
Parametrised successor to the frame histogram block for grey-level statistics. It accumulates per-bin counts from a pixel stream through a 2-stage read-modify-write pipeline with forwarding and saturating counters. A self-timed clear sweep empties the RAM; a readout sweep streams every bin together with its running cumulative sum (CDF) for the equalisation stage. It sits between the grey-conversion pipeline and the equalisation LUT builder.

Parameters:
DATA_WIDTH, 20, bin counter width; counts saturate at 2**DATA_WIDTH-1
ADDR_WIDTH, 8, grey-level width; number of bins NBINS = 2**ADDR_WIDTH
CDF_WIDTH, DATA_WIDTH+ADDR_WIDTH, cumulative-sum width; sized so it never overflows

Ports:
iClk  in  1  clock, all logic on rising edge
iRst_n  in  1  asynchronous active-low reset
iClear  in  1  one-cycle pulse: start clear sweep
iInc  in  1  pixel valid: increment bin iGray
iGray  in  ADDR_WIDTH  pixel grey level
iReadStart  in  1  one-cycle pulse: start readout sweep
oBusy  out  1  high in CLEAR, DRAIN, READ; increments are dropped while high
oValid  out  1  readout beat valid
oBin  out  ADDR_WIDTH  bin index of the current beat
oCount  out  DATA_WIDTH  count of oBin
oCdf  out  CDF_WIDTH  sum of counts of bins 0..oBin inclusive
oDone  out  1  one-cycle pulse after the last readout beat
oSat  out  1  sticky: some bin saturated since the last clear

Behaviour:
- Reset (async): all outputs 0, pipeline valids 0, oSat 0. On release the FSM enters CLEAR, because RAM contents are undefined.
- FSM states: CLEAR, IDLE, DRAIN, READ.
- CLEAR: the sweep counter writes 0 to bins 0..NBINS-1, one per cycle, then enters IDLE. oBusy=1 throughout. Clearing also zeroes oSat.
- IDLE: oBusy=0.
  - iClear goes to CLEAR (counter restarts at 0).
  - iReadStart goes to DRAIN.
  - iClear and iReadStart together: iClear wins.
- DRAIN: waits until both RMW stages are empty (at most 2 cycles), then enters READ at bin 0.
- READ: one bin per cycle, bins 0..NBINS-1 in order.
  - RAM read is registered, so oValid first rises 2 cycles after entering READ.
  - oCdf accumulates oCount; oCdf for bin 0 equals oCount.
  - oDone pulses the cycle after the final beat, then the FSM returns to IDLE.
  - iClear during READ aborts immediately to CLEAR: oValid drops next cycle and oDone does not pulse.
  - iReadStart during READ or CLEAR is ignored.
- Accumulate pipeline (IDLE only; iInc is ignored in any other state):
  - Stage R registers the address and reads RAM.
  - Stage W computes new = min(old+1, 2**DATA_WIDTH-1) and writes it.
  - If a stage-R bin equals the stage-W bin, the forwarded stage-W write value replaces the RAM read.
  - Result: back-to-back and every-other-cycle hits on one bin count exactly once each.
  - Throughput 1 pixel/cycle. An increment is visible to readout 2 cycles after acceptance.
- Saturation: a bin at max stays at max; oSat sets on the cycle such an increment is attempted.
- iClear while increments are in the pipeline: in-flight writes are squashed, so no bin is nonzero after the sweep.
- RAM: single-port-write / single-read inferred block, NBINS x DATA_WIDTH. The write port is shared by the clear sweep and stage W; they are mutually exclusive by state.

Decomposition:
- Package histogram_pkg holds:
  - the state enum (CLEAR, IDLE, DRAIN, READ);
  - the NBINS derivation;
  - saturation constant function max_count(DATA_WIDTH).
- One sub-module, histogram_ram: parametrised simple dual-port RAM with a registered read, reused by the LUT builder.
- FSM, forwarding and CDF accumulator stay in histogram_engine.

Test Plan:
- Release reset -> oBusy=1 for exactly 256 cycles; then a readout shows all 256 oCount=0 and final oCdf=0, with oDone pulsing once.
- Inc bin 7 for 5 consecutive cycles, then bin 7/bin 9 alternating 4 cycles, then readout -> bin7=7, bin9=2, oCdf at bin 255 = 9.
- DATA_WIDTH=4: 20 incs to bin 3 -> oCount=15 and oSat=1; after iClear and the sweep, oSat=0.
- Incs of 1 to every bin, then readout -> oCdf at bin k = k+1; last beat oCdf=256; oValid is high for 256 contiguous cycles.
- iInc pulsed during CLEAR and READ -> counts unchanged. iInc and iReadStart on the same cycle in IDLE -> that pixel is counted.
- iClear at readout beat 100 -> oValid drops next cycle, no oDone, then 256-cycle sweep, and a subsequent readout is all zero.
